dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port A does single
// CPU accesses, port B does non-preemptible DMA bursts, round-robin on contention.
module dmem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_len,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SVC_A = 2'd1;
    localparam logic [1:0] SVC_B = 2'd2;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bdir_q, bdir_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              b_rvalid_q, b_rvalid_d;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        baddr_d    = baddr_q;
        cnt_d      = cnt_q;
        bdir_d     = bdir_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        b_rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A wins unless B is also asking and A was the last one served
                if (a_req && (!b_req || last_q == GRANT_B)) begin
                    state_d = SVC_A;
                end else if (b_req) begin
                    state_d = SVC_B;
                    baddr_d = b_addr;
                    cnt_d   = b_len;
                    bdir_d  = b_we;
                end
            end
            SVC_A: begin
                state_d = IDLE;
                last_d  = GRANT_A;
                if (!a_we) begin
                    a_rdata_d = mem_spo;
                end
            end
            SVC_B: begin
                baddr_d = baddr_q + ADDR_ONE;
                cnt_d   = cnt_q - 8'd1;
                if (!bdir_q) begin
                    b_rdata_d  = mem_spo;
                    b_rvalid_d = 1'b1;
                end
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    last_d  = GRANT_B;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_ack  = 1'b0;
        b_ack  = 1'b0;
        b_done = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        case (state_q)
            SVC_A: begin
                a_ack  = 1'b1;
                mem_a  = a_addr;
                mem_d  = a_wdata;
                mem_we = a_we;
            end
            SVC_B: begin
                b_ack  = 1'b1;
                b_done = (cnt_q == 8'd0);
                mem_a  = baddr_q;
                mem_d  = b_wdata;
                mem_we = bdir_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= GRANT_B;
            baddr_q    <= '0;
            cnt_q      <= 8'd0;
            bdir_q     <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            baddr_q    <= baddr_d;
            cnt_q      <= cnt_d;
            bdir_q     <= bdir_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: drives directed and random transactions
// against a 2048-word memory model and a transaction-level reference memory.
module tb_dmem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              a_req, a_we, a_ack;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata;
    logic              b_req, b_we, b_ack, b_done, b_rvalid;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_len;
    logic [DATA_W-1:0] b_wdata, b_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d, mem_spo;
    logic              mem_we;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_a_rdata;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_done(b_done),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
    );

    function automatic logic [DATA_W-1:0] seed_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // External memory: combinational read, write on posedge
    assign mem_spo = mem[mem_a];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = seed_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_a] <= mem_d;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory activity must always belong to exactly one granted port
    always @(negedge clk) begin
        if (!rst) begin
            check_output("one_port_per_cycle", {63'd0, a_ack & b_ack}, 64'd0);
            check_output("we_without_grant", {63'd0, mem_we & ~(a_ack | b_ack)}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_a_ack"}, a_ack, 0);
        check_output({tag, "_b_ack"}, b_ack, 0);
        check_output({tag, "_b_done"}, b_done, 0);
        check_output({tag, "_mem_we"}, mem_we, 0);
        check_output({tag, "_mem_a"}, mem_a, 0);
        check_output({tag, "_mem_d"}, mem_d, 0);
        check_output({tag, "_b_rvalid"}, b_rvalid, 0);
        check_output({tag, "_a_rdata"}, a_rdata, 0);
        check_output({tag, "_b_rdata"}, b_rdata, 0);
    endtask

    task automatic apply_reset(input string tag);
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_len = '0; b_wdata = '0;
        rst = 1'b1;
        #1;
        check_idle_outputs(tag);
        exp_a_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Single A access starting from an idle arbiter
    task automatic a_access(input bit we, input int addr, input logic [DATA_W-1:0] wd, input string tag);
        a_req = 1; a_we = we; a_addr = ADDR_W'(addr); a_wdata = wd;
        sample();
        check_output({tag, "_ack_early"}, a_ack, 0);
        step();
        sample();
        check_output({tag, "_ack"}, a_ack, 1);
        check_output({tag, "_mem_a"}, mem_a, 64'(addr));
        check_output({tag, "_mem_we"}, mem_we, {63'd0, we});
        step();
        a_req = 0;
        if (we) ref_mem[addr] = wd;
        else exp_a_rdata = ref_mem[addr];
        check_output({tag, "_rdata"}, a_rdata, exp_a_rdata);
        check_output({tag, "_mem"}, mem[addr], ref_mem[addr]);
    endtask

    // B burst; optionally raises an A read during beat a_beat
    task automatic b_burst(input bit we, input int addr, input int len, input int a_beat,
                           input int a_rd_addr, input bit seq_data, input string tag);
        logic [DATA_W-1:0] wd[$];
        int ad;
        for (int k = 0; k <= len; k++) wd.push_back(seq_data ? DATA_W'(k + 1) : $urandom);
        b_req = 1; b_we = we; b_addr = ADDR_W'(addr); b_len = 8'(len); b_wdata = wd[0];
        sample();
        check_output({tag, "_ack_early"}, b_ack, 0);
        step();
        for (int k = 0; k <= len; k++) begin
            ad = (addr + k) % DEPTH;
            if (k == a_beat) begin
                a_req = 1; a_we = 0; a_addr = ADDR_W'(a_rd_addr);
            end
            if (k > 0) begin
                b_addr = ADDR_W'($urandom); b_len = 8'($urandom); b_we = 1'($urandom);
            end
            b_wdata = wd[k];
            sample();
            check_output({tag, "_b_ack"}, b_ack, 1);
            check_output({tag, "_b_done"}, b_done, {63'd0, k == len});
            check_output({tag, "_mem_a"}, mem_a, 64'(ad));
            check_output({tag, "_mem_we"}, mem_we, {63'd0, we});
            check_output({tag, "_a_blocked"}, a_ack, 0);
            step();
            if (we) begin
                ref_mem[ad] = wd[k];
                check_output({tag, "_rvalid_wr"}, b_rvalid, 0);
            end else begin
                check_output({tag, "_rvalid"}, b_rvalid, 1);
                check_output({tag, "_rdata"}, b_rdata, ref_mem[ad]);
            end
        end
        b_req = 0; b_we = 0;
        sample();
        check_output({tag, "_idle_b_ack"}, b_ack, 0);
        check_output({tag, "_idle_a_ack"}, a_ack, 0);
        step();
        check_output({tag, "_rvalid_end"}, b_rvalid, 0);
        if (a_beat >= 0) begin
            sample();
            check_output({tag, "_a_ack"}, a_ack, 1);
            check_output({tag, "_a_mem_a"}, mem_a, 64'(a_rd_addr));
            check_output({tag, "_a_mem_we"}, mem_we, 0);
            step();
            a_req = 0;
            exp_a_rdata = ref_mem[a_rd_addr];
            check_output({tag, "_a_rdata"}, a_rdata, exp_a_rdata);
        end
        for (int k = 0; k <= len; k++) begin
            ad = (addr + k) % DEPTH;
            check_output({tag, "_mem"}, mem[ad], ref_mem[ad]);
        end
    endtask

    initial begin
        byte grant_who [$];
        int  grant_cyc [$];
        int  base;
        logic [DATA_W-1:0] rd [8];

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        apply_reset("reset");

        a_access(0, 5, '0, "a_read5");
        check_output("a_read5_value", a_rdata, 64'hDEADBEEF);
        b_burst(1, 2046, 3, -1, 0, 1, "b_wr_wrap");
        check_output("wrap_mem0", mem[0], 3);
        check_output("wrap_mem1", mem[1], 4);
        b_burst(0, 10, 1, -1, 0, 0, "b_rd10");
        b_burst(1, 300, 7, 2, 2047, 0, "a_during_b");
        a_access(1, 77, 32'hCAFE0001, "a_write");

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1)
                a_access(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom, "rand_a");
            else
                b_burst(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 5),
                        -1, 0, 0, "rand_b");
        end

        // Both ports request together and keep requesting
        apply_reset("reset2");
        a_req = 1; a_we = 0; a_addr = 11'd20;
        b_req = 1; b_we = 0; b_addr = 11'd40; b_len = 8'd0;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (a_ack) begin grant_who.push_back("A"); grant_cyc.push_back(c); end
            if (b_ack) begin grant_who.push_back("B"); grant_cyc.push_back(c); end
            step();
        end
        a_req = 0; b_req = 0;
        exp_a_rdata = ref_mem[20];
        check_output("contention_count", grant_who.size(), 6);
        foreach (grant_who[i]) begin
            check_output("contention_order", grant_who[i], (i % 2 == 0) ? "A" : "B");
            check_output("contention_cycle", grant_cyc[i], 2 * i + 1);
        end
        check_output("contention_a_rdata", a_rdata, exp_a_rdata);

        // Asynchronous reset in the middle of an 8-beat write burst
        step();
        base = 500;
        for (int k = 0; k < 8; k++) rd[k] = $urandom;
        b_req = 1; b_we = 1; b_addr = 11'(base); b_len = 8'd7; b_wdata = rd[0];
        step();
        for (int k = 0; k < 2; k++) begin
            b_wdata = rd[k];
            step();
            ref_mem[base + k] = rd[k];
        end
        b_wdata = rd[2];
        sample();
        check_output("rst_burst_active", mem_we, 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid_burst");
        step();
        step();
        b_req = 0;
        rst = 1'b0;
        exp_a_rdata = '0;
        sample();
        check_output("rst_no_resume", b_ack, 0);
        for (int k = 0; k < 8; k++)
            check_output("rst_burst_mem", mem[base + k], ref_mem[base + k]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
